// File: rtl/loader_pkg.sv
// loader_pkg: shared types and constants for the UART boot loader.
// Imported by boot_loader_ctrl and loader_word_assembler.
package loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
    S_FINISH,
    S_ERROR
  } loader_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  localparam int         LEN_BYTES         = 2;
  localparam int         WORD_BYTES        = 4;

  function automatic logic [31:0] word_addr(
    input logic [31:0] base,
    input logic [31:0] idx
  );
    return base + (idx << 2);
  endfunction

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler: packs LSB-first bytes into 32-bit words.
// word_valid_o strobes in the cycle the 4th byte is presented.
module loader_word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  localparam logic [1:0] LAST_IDX = 2'(WORD_BYTES - 1);

  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [23:0] shift_q, shift_d;

  // Byte-lane steering and completion strobe for the current byte.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    shift_d      = shift_q;
    word_valid_o = en_i && (byte_cnt_q == LAST_IDX);
    word_o       = {byte_i, shift_q};
    if (clear_i) begin
      byte_cnt_d = '0;
      shift_d    = '0;
    end else if (en_i) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
      unique case (byte_cnt_q)
        2'd0:    shift_d[7:0]   = byte_i;
        2'd1:    shift_d[15:8]  = byte_i;
        2'd2:    shift_d[23:16] = byte_i;
        default: shift_d        = shift_q;
      endcase
    end
  end

  // Byte counter and partial-word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
    end
  end

endmodule

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl: loads a UART image into imem, then releases core.
// Optional inter-byte timeout enabled by LOADER_TIMEOUT_EN.
module boot_loader_ctrl
  import loader_pkg::*;
#(
  parameter int          ADDR_W         = 10,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int          CNT_W     = ADDR_W + 1;
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  loader_state_t state_q, state_d;

  logic             core_rst_q, core_rst_d;
  logic             we_q, we_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [7:0]       len_lo_q, len_lo_d;
  logic             last_q, last_d;

  logic [CNT_W-1:0] words_nxt;
  logic [16:0]      len_full;
  logic             asm_clear;
  logic             asm_en;
  logic             word_valid;
  logic [31:0]      word;
  logic             tmo_hit;

  loader_word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (asm_clear),
    .en_i         (asm_en),
    .byte_i       (rx_byte),
    .word_valid_o (word_valid),
    .word_o       (word)
  );

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST =
    TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Count silent cycles while a frame is open; any byte clears it.
  always_comb begin
    tmo_d   = '0;
    tmo_hit = 1'b0;
    if (state_q inside {S_LEN_LO, S_LEN_HI, S_DATA}) begin
      if (!rx_valid) begin
        tmo_d   = tmo_q + 1'b1;
        tmo_hit = (tmo_q == TMO_LAST) && !last_q;
      end
    end
  end

  // Silent-cycle counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES != 0);
  assign tmo_hit    = 1'b0;
`endif

  assign words_nxt = words_q + 1'b1;
  assign len_full  = {1'b0, rx_byte, len_lo_q};

  // Frame parser: next state, write strobe and status outputs.
  always_comb begin
    state_d    = state_q;
    core_rst_d = core_rst_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    busy_d     = busy_q;
    done_d     = done_q;
    error_d    = error_q;
    words_d    = words_q;
    len_d      = len_q;
    len_lo_d   = len_lo_q;
    last_d     = last_q;
    asm_clear  = 1'b0;
    asm_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d    = S_LEN_LO;
          busy_d     = 1'b1;
          done_d     = 1'b0;
          error_d    = 1'b0;
          words_d    = '0;
          core_rst_d = 1'b1;
          addr_d     = BASE_ADDR;
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_lo_d = rx_byte;
          state_d  = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          if (len_full == '0) begin
            state_d = S_FINISH;
          end else if (len_full > MAX_WORDS) begin
            state_d = S_ERROR;
          end else begin
            state_d   = S_DATA;
            len_d     = len_full[CNT_W-1:0];
            last_d    = 1'b0;
            asm_clear = 1'b1;
          end
        end
      end
      S_DATA: begin
        if (last_q) begin
          state_d = S_FINISH;
        end else begin
          asm_en = rx_valid;
          if (word_valid) begin
            we_d    = 1'b1;
            wdata_d = word;
            addr_d  = word_addr(BASE_ADDR, 32'(words_q));
            words_d = words_nxt;
            last_d  = (words_nxt == len_q);
          end
        end
      end
      S_FINISH: begin
        busy_d     = 1'b0;
        done_d     = 1'b1;
        core_rst_d = 1'b0;
        last_d     = 1'b0;
        state_d    = S_IDLE;
      end
      S_ERROR: begin
        busy_d     = 1'b0;
        error_d    = 1'b1;
        core_rst_d = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) state_d = S_ERROR;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      core_rst_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= BASE_ADDR;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      words_q    <= '0;
      len_q      <= '0;
      len_lo_q   <= '0;
      last_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      core_rst_q <= core_rst_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      words_q    <= words_d;
      len_q      <= len_d;
      len_lo_q   <= len_lo_d;
      last_q     <= last_d;
    end
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign core_rst     = core_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// tb_boot_loader_ctrl: randomized frames checked against a byte-stream
// model of the frame format; writes checked by a scoreboard monitor.
module tb_boot_loader_ctrl;

  localparam int          ADDR_W = 10;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam int          TMO    = 100;

  localparam int OUT_NONE = 0;
  localparam int OUT_DONE = 1;
  localparam int OUT_ERR  = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            rx_valid = 1'b0;
  logic [7:0]      rx_byte = 8'h00;
  logic            imem_we;
  logic [31:0]     imem_addr;
  logic [31:0]     imem_wdata;
  logic            core_rst;
  logic            busy;
  logic            done;
  logic            error;
  logic [ADDR_W:0] words_loaded;

  boot_loader_ctrl #(
    .ADDR_W         (ADDR_W),
    .BASE_ADDR      (BASE),
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_valid     (rx_valid),
    .rx_byte      (rx_byte),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .core_rst     (core_rst),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  int viol  = 0;

  logic [7:0]  stim[$];
  int          drv_cyc[$];
  logic [31:0] ex_addr[$];
  logic [31:0] ex_data[$];
  int          ex_idx[$];
  int          ex_out;
  int          ex_words;

  // Expected {busy,done,error,core_rst} after a frame outcome.
  function automatic logic [3:0] exp_status(input int o);
    case (o)
      OUT_DONE: return 4'b0100;
      OUT_ERR:  return 4'b0011;
      default:  return 4'b1001;
    endcase
  endfunction

  // Parse stim as the frame format describes; list expected writes.
  task automatic ref_model(input bit synced);
    int i;
    int n;
    ex_addr.delete();
    ex_data.delete();
    ex_idx.delete();
    ex_out   = OUT_NONE;
    ex_words = 0;
    i = 0;
    if (!synced) begin
      while (i < stim.size() && stim[i] != 8'hA5) i++;
      i++;
    end
    if (i + 2 > stim.size()) return;
    n = int'({stim[i+1], stim[i]});
    i += 2;
    if (n == 0) begin
      ex_out = OUT_DONE;
      return;
    end
    if (n > (1 << ADDR_W)) begin
      ex_out = OUT_ERR;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (i + 4 > stim.size()) return;
      ex_addr.push_back(BASE + 32'(4 * w));
      ex_data.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
      ex_idx.push_back(i + 3);
      ex_words++;
      i += 4;
    end
    ex_out = OUT_DONE;
  endtask

  // Drive stim; gap < 0 picks a random 0..3 idle gap per byte.
  task automatic send_stim(input int gap);
    int g;
    drv_cyc.delete();
    foreach (stim[i]) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_byte  = stim[i];
      drv_cyc.push_back(cyc);
      g = (gap < 0) ? int'($urandom_range(3)) : gap;
      repeat (g) begin
        @(negedge clk);
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
      end
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Scoreboard: every write must match the next expected word and
  // land exactly one cycle after its 4th byte was presented.
  always @(negedge clk) begin
    logic [31:0] a;
    logic [31:0] d;
    int k;
    int ec;
    if (busy && !core_rst) viol++;
    if (imem_we && !core_rst) viol++;
    if (imem_we) begin
      n_cmp++;
      if (ex_addr.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write addr=%h data=%h cyc=%0d",
                 imem_addr, imem_wdata, cyc);
      end else begin
        a  = ex_addr.pop_front();
        d  = ex_data.pop_front();
        k  = ex_idx.pop_front();
        ec = (k < drv_cyc.size()) ? drv_cyc[k] + 1 : -1;
        if (imem_addr !== a || imem_wdata !== d || cyc !== ec) begin
          n_bad++;
          $display("FAIL write got %h@%h cyc %0d want %h@%h cyc %0d",
                   imem_wdata, imem_addr, cyc, d, a, ec);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({core_rst, imem_we, busy, done, error} !== 5'b10000) begin
      n_bad++;
      $display("FAIL reset_flags got %b want 10000",
               {core_rst, imem_we, busy, done, error});
    end
    n_cmp++;
    if (imem_addr !== BASE || imem_wdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_bus got %h/%h want %h/0",
               imem_addr, imem_wdata, BASE);
    end
    n_cmp++;
    if (words_loaded !== '0) begin
      n_bad++;
      $display("FAIL reset_words got %0d want 0", words_loaded);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input int gap);
    stim = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
             8'hEF, 8'hBE, 8'hAD, 8'hDE};
    ref_model(1'b0);
    send_stim(gap);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL basic_status gap %0d got %b want %b", gap,
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (words_loaded !== 11'(ex_words)) begin
      n_bad++;
      $display("FAIL basic_words gap %0d got %0d want %0d", gap,
               words_loaded, ex_words);
    end
    n_cmp++;
    if (ex_addr.size() != 0) begin
      n_bad++;
      $display("FAIL basic_missing gap %0d got %0d pending want 0",
               gap, ex_addr.size());
    end
  endtask

  task automatic test_junk_zero();
    stim = '{8'h00, 8'h11, 8'hA5, 8'h00, 8'h00};
    ref_model(1'b0);
    send_stim(0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL zero_len_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (words_loaded !== 11'(ex_words)) begin
      n_bad++;
      $display("FAIL zero_len_words got %0d want %0d",
               words_loaded, ex_words);
    end
  endtask

  task automatic test_oversize();
    stim = '{8'hA5, 8'h01, 8'h04};
    ref_model(1'b0);
    send_stim(0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL oversize_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    stim = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    ref_model(1'b0);
    send_stim(1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL after_err_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (ex_addr.size() != 0) begin
      n_bad++;
      $display("FAIL after_err_missing got %0d pending want 0",
               ex_addr.size());
    end
  endtask

  task automatic test_max_len();
    stim = '{8'hA5, 8'h00, 8'h04};
    for (int i = 0; i < 4 * (1 << ADDR_W); i++)
      stim.push_back(8'($urandom));
    ref_model(1'b0);
    send_stim(0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL max_len_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (words_loaded !== 11'(ex_words)) begin
      n_bad++;
      $display("FAIL max_len_words got %0d want %0d",
               words_loaded, ex_words);
    end
    n_cmp++;
    if (ex_addr.size() != 0) begin
      n_bad++;
      $display("FAIL max_len_missing got %0d pending want 0",
               ex_addr.size());
    end
  endtask

  task automatic test_rst_mid();
    stim = '{8'hA5, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC};
    ref_model(1'b0);
    send_stim(0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({core_rst, imem_we, busy, done, error} !== 5'b10000) begin
      n_bad++;
      $display("FAIL mid_rst_flags got %b want 10000",
               {core_rst, imem_we, busy, done, error});
    end
    n_cmp++;
    if (imem_addr !== BASE || imem_wdata !== 32'h0 ||
        words_loaded !== '0) begin
      n_bad++;
      $display("FAIL mid_rst_bus got %h/%h/%0d want %h/0/0",
               imem_addr, imem_wdata, words_loaded, BASE);
    end
    @(negedge clk);
    rst = 1'b0;
    stim = '{8'hA5, 8'h01, 8'h00, 8'hDD, 8'hEE, 8'hFF, 8'h11};
    ref_model(1'b0);
    send_stim(0);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL post_rst_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (ex_addr.size() != 0) begin
      n_bad++;
      $display("FAIL post_rst_missing got %0d pending want 0",
               ex_addr.size());
    end
  endtask

  task automatic test_reload();
    n_cmp++;
    if (done !== 1'b1 || core_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL reload_pre got done %b core_rst %b want 1 0",
               done, core_rst);
    end
    stim = '{8'hA5};
    ref_model(1'b0);
    send_stim(0);
    n_cmp++;
    if ({busy, done, error, core_rst} !== 4'b1001) begin
      n_bad++;
      $display("FAIL reload_sync got %b want 1001",
               {busy, done, error, core_rst});
    end
    stim = '{8'h02, 8'h00};
    for (int i = 0; i < 8; i++) stim.push_back(8'($urandom));
    ref_model(1'b1);
    send_stim(-1);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== exp_status(ex_out)) begin
      n_bad++;
      $display("FAIL reload_status got %b want %b",
               {busy, done, error, core_rst}, exp_status(ex_out));
    end
    n_cmp++;
    if (ex_addr.size() != 0) begin
      n_bad++;
      $display("FAIL reload_missing got %0d pending want 0",
               ex_addr.size());
    end
  endtask

  task automatic test_random();
    int nw;
    int nj;
    logic [7:0] b;
    for (int f = 0; f < 8; f++) begin
      stim.delete();
      nj = int'($urandom_range(3));
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      nw = int'($urandom_range(1, 6));
      stim.push_back(8'hA5);
      stim.push_back(8'(nw));
      stim.push_back(8'h00);
      for (int j = 0; j < 4 * nw; j++) stim.push_back(8'($urandom));
      ref_model(1'b0);
      send_stim(-1);
      repeat (6) @(negedge clk);
      n_cmp++;
      if ({busy, done, error, core_rst} !== exp_status(ex_out) ||
          words_loaded !== 11'(ex_words)) begin
        n_bad++;
        $display("FAIL random_%0d got %b/%0d want %b/%0d", f,
                 {busy, done, error, core_rst}, words_loaded,
                 exp_status(ex_out), ex_words);
      end
      n_cmp++;
      if (ex_addr.size() != 0) begin
        n_bad++;
        $display("FAIL random_%0d_missing got %0d pending want 0",
                 f, ex_addr.size());
      end
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL core_rst_release got %0d violations want 0",
               viol);
    end
  endtask

  task automatic test_timeout();
    stim = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
    ref_model(1'b0);
    send_stim(0);
    repeat (89) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, core_rst} !== 4'b1001) begin
      n_bad++;
      $display("FAIL silence_90 got %b want 1001",
               {busy, done, error, core_rst});
    end
    repeat (60) @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
    n_cmp++;
    if ({busy, done, error, core_rst} !== 4'b0011) begin
      n_bad++;
      $display("FAIL timeout_err got %b want 0011",
               {busy, done, error, core_rst});
    end
`else
    n_cmp++;
    if ({busy, done, error, core_rst} !== 4'b1001) begin
      n_bad++;
      $display("FAIL no_timeout_wait got %b want 1001",
               {busy, done, error, core_rst});
    end
`endif
    n_cmp++;
    if (ex_addr.size() != 0 || viol != 0) begin
      n_bad++;
      $display("FAIL timeout_tail got %0d pending %0d viol want 0 0",
               ex_addr.size(), viol);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic(0);
    test_basic(5);
    test_junk_zero();
    test_oversize();
    test_rst_mid();
    test_reload();
    test_max_len();
    test_random();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached at cyc %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
